imm_target_pipe: RTL and testbench
==================================

Name: imm_target_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle immediate extender.
- Decodes the instruction format from the opcode and emits one selected sign-extended immediate.
- Computes the PC-relative or fall-through target.
- Sits between fetch and execute as a 2-stage valid/ready pipeline, XLEN-generic (RV32/RV64), with flush support.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- ILEN, 32, instruction width; fixed at 32, exposed for clarity only.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of all in-flight entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  block can accept this cycle.
- in_instr  in  ILEN  instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  sign-extended immediate.
- out_target  out  XLEN  computed target address.
- out_type  out  3  format code: 0=NONE, 1=I, 2=S, 3=B, 4=U, 5=J.
- out_illegal  out  1  opcode has no immediate format.
- out_misalign  out  1  target misaligned (optional feature only; tied 0 otherwise).

Behaviour:
- Opcode decode on instr[6:0]:
  - I-type: 0010011, 0000011, 1100111, 1110011.
  - S-type: 0100011.
  - B-type: 1100011.
  - U-type: 0110111 (LUI), 0010111 (AUIPC).
  - J-type: 1101111.
  - R-type 0110011/0111011: type NONE, imm 0, illegal 0.
  - Any other opcode: type NONE, imm 0, illegal 1.
- Immediate construction (all sign-extended from instr[31] to XLEN):
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}; for XLEN=64, bits 63:32 copy instr[31].
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Target:
  - B, J, AUIPC: pc + imm, modulo 2^XLEN (wrap, no carry out).
  - JALR: pc + 4, since rs1 is not available here.
  - All others: pc + 4, modulo 2^XLEN.
- Pipeline:
  - Stage 1 registers pc, imm, type and illegal.
  - Stage 2 registers target = s1_pc + s1_imm (or + 4).
  - Latency exactly 2 cycles from acceptance to out_valid; throughput 1 per cycle.
- Handshake:
  - Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
  - s2_ready = !s2_valid || out_ready; in_ready = !s1_valid || s2_ready (combinational, no bubble).
  - Under backpressure (out_ready=0), out_* stay stable and at most 2 entries are held.
  - in_ready falls only when both stages are full.
  - out_* must not change while out_valid=1 && out_ready=0.
- Flush:
  - Clears s1_valid and s2_valid the next cycle.
  - An input offered in the flush cycle is dropped; in_ready is still driven per the rule above.
  - flush overrides a simultaneous transfer on either side.
- Reset:
  - All valid bits, out_imm, out_target, out_type, out_illegal and out_misalign are 0.
  - in_ready=1 during and after reset.
  - Reset mid-stream discards all entries.
  - rst has priority over flush.

Optional Feature:
- Macro: IMM_TARGET_MISALIGN_EN.
- When defined, for B/J/AUIPC entries stage 2 sets out_misalign = target[1] | target[0], i.e. a 4-byte alignment check with no compressed-instruction support.
- out_misalign resets to 0 and is 0 for all other types.
- When undefined, out_misalign is constant 0 and no check logic is built.

Test Plan:
- XLEN=32, in_instr=0xFE000CE3 (beq -8), pc=0x100, out_ready=1 -> 2 cycles later out_type=3, out_imm=0xFFFFFFF8, out_target=0x000000F8.
- in_instr=0x001000EF (jal x1,+2048), pc=0x1000 -> out_type=5, out_imm=0x800, out_target=0x1800.
- Back-to-back 0x123452B7 (lui), 0xFFF00093 (addi -1), 0xFE21AE23 (sw -4), pc=0x200/0x204/0x208:
  - Results are 0x12345000/0x204, 0xFFFFFFFF/0x208 and 0xFFFFFFFC/0x20C, on consecutive cycles.
  - Hold out_ready=0 for 3 cycles mid-stream -> outputs stable, in_ready=0 after 2 entries buffered, order preserved with no loss or duplication.
- XLEN=64, in_instr=0x800002B7 (lui 0x80000) -> out_imm=0xFFFFFFFF80000000; in_instr=0x0000007F -> out_illegal=1, out_imm=0.
- Flush asserted with both stages full plus new in_valid -> next cycle out_valid=0, nothing emitted; rst asserted mid-stream -> all outputs 0, in_ready=1.
- With IMM_TARGET_MISALIGN_EN: in_instr=0x0020006F (jal +2), pc=0 -> out_target=0x2, out_misalign=1. Without the macro -> out_misalign=0.

Source files
------------

// File: rtl/imm_target_pipe.sv
`timescale 1ns/1ps
// imm_target_pipe
// Two-stage valid/ready pipeline between fetch and execute. Stage 1 decodes the
// instruction format from the opcode and builds the sign-extended immediate;
// stage 2 produces the PC-relative (B/J/AUIPC) or fall-through (pc + 4) target.
// XLEN selects RV32 (32) or RV64 (64). Flush kills everything in flight.
// Optional build macro IMM_TARGET_MISALIGN_EN: adds a 4-byte alignment check
// of PC-relative targets on out_misalign (otherwise out_misalign is tied 0).
module imm_target_pipe #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target,
  output logic [2:0]      out_type,
  output logic            out_illegal,
  output logic            out_misalign
);

  // Format codes presented on out_type
  localparam logic [2:0] TYPE_NONE = 3'd0;
  localparam logic [2:0] TYPE_I    = 3'd1;
  localparam logic [2:0] TYPE_S    = 3'd2;
  localparam logic [2:0] TYPE_B    = 3'd3;
  localparam logic [2:0] TYPE_U    = 3'd4;
  localparam logic [2:0] TYPE_J    = 3'd5;

  // Major opcodes recognised by the decoder
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  // Decode results (combinational, in front of stage 1)
  logic [31:0]     imm32_next;
  logic [XLEN-1:0] imm_next;
  logic [2:0]      type_next;
  logic            illegal_next;
  logic            pcrel_next;

  // Stage 1 state
  logic            s1_valid_reg;
  logic [XLEN-1:0] s1_pc_reg;
  logic [XLEN-1:0] s1_imm_reg;
  logic [2:0]      s1_type_reg;
  logic            s1_illegal_reg;
  logic            s1_pcrel_reg;

  // Stage 2 state (drives the outputs directly)
  logic            s2_valid_reg;
  logic [XLEN-1:0] s2_imm_reg;
  logic [XLEN-1:0] s2_target_reg;
  logic [2:0]      s2_type_reg;
  logic            s2_illegal_reg;

  logic            s2_ready;
  logic [XLEN-1:0] target_next;

  // Opcode decode and 32-bit immediate assembly; every immediate is signed by instr[31]
  always_comb begin
    imm32_next   = '0;
    type_next    = TYPE_NONE;
    illegal_next = 1'b0;
    pcrel_next   = 1'b0;
    case (in_instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
        type_next  = TYPE_I;
        imm32_next = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_STORE: begin
        type_next  = TYPE_S;
        imm32_next = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OP_BRANCH: begin
        type_next  = TYPE_B;
        pcrel_next = 1'b1;
        imm32_next = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
      end
      OP_LUI: begin
        type_next  = TYPE_U;
        imm32_next = {in_instr[31:12], 12'b0};
      end
      OP_AUIPC: begin
        type_next  = TYPE_U;
        pcrel_next = 1'b1;
        imm32_next = {in_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        type_next  = TYPE_J;
        pcrel_next = 1'b1;
        imm32_next = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};
      end
      OP_OP, OP_OP32: begin
        // register-register forms: legal, no immediate
      end
      default: begin
        illegal_next = 1'b1;
      end
    endcase
  end

  // Widen the 32-bit immediate to XLEN by replicating its sign bit (no-op for RV32)
  assign imm_next[31:0] = imm32_next;
  genvar gi;
  generate
    for (gi = 32; gi < XLEN; gi++) begin : g_sext
      assign imm_next[gi] = imm32_next[31];
    end
  endgenerate

  // Handshake: a stage can take new data when empty or when its content moves on this cycle.
  // in_ready is also held high while reset is asserted.
  assign s2_ready = !s2_valid_reg || out_ready;
  assign in_ready = rst || !s1_valid_reg || s2_ready;

  // JALR falls through like every other non-PC-relative format (rs1 is unknown here)
  assign target_next = s1_pc_reg + (s1_pcrel_reg ? s1_imm_reg : PC_STEP);

  // Stage 1 register: captures pc and decode results of an accepted instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg   <= 1'b0;
      s1_pc_reg      <= '0;
      s1_imm_reg     <= '0;
      s1_type_reg    <= TYPE_NONE;
      s1_illegal_reg <= 1'b0;
      s1_pcrel_reg   <= 1'b0;
    end else if (flush) begin
      s1_valid_reg <= 1'b0;
    end else if (in_ready) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_pc_reg      <= in_pc;
        s1_imm_reg     <= imm_next;
        s1_type_reg    <= type_next;
        s1_illegal_reg <= illegal_next;
        s1_pcrel_reg   <= pcrel_next;
      end
    end
  end

  // Stage 2 register: holds the result stable until downstream takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg   <= 1'b0;
      s2_imm_reg     <= '0;
      s2_target_reg  <= '0;
      s2_type_reg    <= TYPE_NONE;
      s2_illegal_reg <= 1'b0;
    end else if (flush) begin
      s2_valid_reg <= 1'b0;
    end else if (s2_ready) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_imm_reg     <= s1_imm_reg;
        s2_target_reg  <= target_next;
        s2_type_reg    <= s1_type_reg;
        s2_illegal_reg <= s1_illegal_reg;
      end
    end
  end

`ifdef IMM_TARGET_MISALIGN_EN
  logic s2_misalign_reg;

  // Stage 2 alignment flag: PC-relative targets must be 4-byte aligned
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_misalign_reg <= 1'b0;
    end else if (!flush && s2_ready && s1_valid_reg) begin
      s2_misalign_reg <= s1_pcrel_reg & (|target_next[1:0]);
    end
  end

  assign out_misalign = s2_misalign_reg;
`else
  assign out_misalign = 1'b0;
`endif

  assign out_valid   = s2_valid_reg;
  assign out_imm     = s2_imm_reg;
  assign out_target  = s2_target_reg;
  assign out_type    = s2_type_reg;
  assign out_illegal = s2_illegal_reg;

endmodule

// File: tb/tb_imm_target_pipe.sv
`timescale 1ns/1ps
// tb_imm_target_pipe
// Drives an RV32 and an RV64 instance in lockstep (same instruction, the RV32
// pc is the low half of the RV64 pc). Directed table, multi-cycle handshake
// sequences, and randomized traffic checked against an arithmetic reference model.
module tb_imm_target_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc32;
  logic [63:0] in_pc64;

  logic        in_ready32, out_valid32, out_illegal32, out_misalign32;
  logic [31:0] out_imm32, out_target32;
  logic [2:0]  out_type32;
  logic        in_ready64, out_valid64, out_illegal64, out_misalign64;
  logic [63:0] out_imm64, out_target64;
  logic [2:0]  out_type64;

  imm_target_pipe #(.XLEN(32), .ILEN(32)) u_dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_pc(in_pc32), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_target(out_target32), .out_type(out_type32),
    .out_illegal(out_illegal32), .out_misalign(out_misalign32)
  );

  imm_target_pipe #(.XLEN(64), .ILEN(32)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_pc(in_pc64), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_target(out_target64), .out_type(out_type64),
    .out_illegal(out_illegal64), .out_misalign(out_misalign64)
  );

  typedef struct {
    logic [63:0] imm;
    logic [63:0] target;
    logic [2:0]  typ;
    logic        ill;
    logic        mis;
    int          acc_cyc;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [63:0] target;
    logic [2:0]  typ;
    logic        ill;
  } row_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t sb[$];
  logic exact_lat = 1'b0;
  logic s_in_ready;

  logic        hold_v = 1'b0;
  logic [31:0] h_imm32, h_tgt32;
  logic [63:0] h_imm64, h_tgt64;
  logic [2:0]  h_type;
  logic        h_ill, h_mis;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic logic exp_mis(logic [31:0] instr, logic [63:0] tgt);
    logic en;
`ifdef IMM_TARGET_MISALIGN_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    return en && (instr[6:0] == 7'h63 || instr[6:0] == 7'h6F || instr[6:0] == 7'h17)
              && (tgt[1:0] != 2'b00);
  endfunction

  // Reference model: immediates rebuilt with signed shifts and masks on 64-bit integers
  function automatic exp_t ref_model(logic [31:0] instr, logic [63:0] pc);
    exp_t   e;
    longint s, u, imm;
    logic   rel;
    s = longint'($signed(instr));
    u = longint'({32'b0, instr});
    imm = 0; rel = 1'b0;
    e.typ = 3'd0; e.ill = 1'b0;
    case (instr[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: begin e.typ = 3'd1; imm = s >>> 20; end
      7'h23: begin e.typ = 3'd2; imm = ((s >>> 25) <<< 5) + ((u >> 7) & 31); end
      7'h63: begin
        e.typ = 3'd3; rel = 1'b1;
        imm = ((s >>> 31) <<< 12) + (((u >> 7) & 1) << 11) + (((u >> 25) & 63) << 5)
            + (((u >> 8) & 15) << 1);
      end
      7'h37: begin e.typ = 3'd4; imm = (s >>> 12) <<< 12; end
      7'h17: begin e.typ = 3'd4; rel = 1'b1; imm = (s >>> 12) <<< 12; end
      7'h6F: begin
        e.typ = 3'd5; rel = 1'b1;
        imm = ((s >>> 31) <<< 20) + (((u >> 12) & 255) << 12) + (((u >> 20) & 1) << 11)
            + (((u >> 21) & 1023) << 1);
      end
      7'h33, 7'h3B: begin end
      default: e.ill = 1'b1;
    endcase
    e.imm     = imm;
    e.target  = rel ? pc + e.imm : pc + 64'd4;
    e.mis     = exp_mis(instr, e.target);
    e.acc_cyc = 0;
    return e;
  endfunction

  function automatic exp_t from_row(row_t r);
    exp_t e;
    e.imm = r.imm; e.target = r.target; e.typ = r.typ; e.ill = r.ill;
    e.mis = exp_mis(r.instr, r.target);
    e.acc_cyc = 0;
    return e;
  endfunction

  // One clock cycle: drive, sample mid-cycle, score transfers
  task automatic step(input logic v, input logic [31:0] instr, input logic [63:0] pc,
                      input logic ordy, input logic fl, input logic r, input exp_t e);
    exp_t x, got;
    int   lat;
    @(posedge clk); #1;
    rst = r; flush = fl; in_valid = v; in_instr = instr;
    in_pc64 = pc; in_pc32 = pc[31:0]; out_ready = ordy;
    #1;
    cyc++;
    s_in_ready = in_ready32;
    if (hold_v) begin
      chk("hold_valid", out_valid32, 1);
      chk("hold_imm32", out_imm32, h_imm32);
      chk("hold_tgt32", out_target32, h_tgt32);
      chk("hold_imm64", out_imm64, h_imm64);
      chk("hold_tgt64", out_target64, h_tgt64);
      chk("hold_type", out_type32, h_type);
      chk("hold_ill", out_illegal32, h_ill);
      chk("hold_mis", out_misalign32, h_mis);
    end
    hold_v = out_valid32 && !ordy && !fl && !r;
    h_imm32 = out_imm32; h_tgt32 = out_target32; h_imm64 = out_imm64; h_tgt64 = out_target64;
    h_type = out_type32; h_ill = out_illegal32; h_mis = out_misalign32;
    if (out_valid32 && ordy && !fl && !r) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL spurious_out: actual=out_valid with imm %h, required=no output (cycle %0d)",
                 out_imm32, cyc);
      end else begin
        got = sb.pop_front();
        $display("[TB] cyc %0d out type=%0d imm=%h target=%h illegal=%0d misalign=%0d",
                 cyc, out_type64, out_imm64, out_target64, out_illegal64, out_misalign64);
        chk("imm32", out_imm32, got.imm[31:0]);
        chk("tgt32", out_target32, got.target[31:0]);
        chk("type32", out_type32, got.typ);
        chk("ill32", out_illegal32, got.ill);
        chk("mis32", out_misalign32, got.mis);
        chk("valid64", out_valid64, 1);
        chk("imm64", out_imm64, got.imm);
        chk("tgt64", out_target64, got.target);
        chk("type64", out_type64, got.typ);
        chk("ill64", out_illegal64, got.ill);
        chk("mis64", out_misalign64, got.mis);
        lat = cyc - got.acc_cyc;
        if (exact_lat) chk("latency", lat, 2);
        else           chk("latency_min", (lat >= 2), 1);
      end
    end
    if (v && in_ready32 && !fl && !r) begin
      x = e;
      x.acc_cyc = cyc;
      sb.push_back(x);
    end
    if (fl || r) sb.delete();
  endtask

  exp_t nul = '{imm: 64'd0, target: 64'd0, typ: 3'd0, ill: 1'b0, mis: 1'b0, acc_cyc: 0};

  // Run with out_ready high until every accepted entry has left (bounded)
  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) step(0, 0, 0, 1, 0, 0, nul);
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic check_cleared(string tag);
    chk({tag, "_valid32"}, out_valid32, 0);
    chk({tag, "_valid64"}, out_valid64, 0);
    chk({tag, "_imm"}, out_imm64, 0);
    chk({tag, "_tgt"}, out_target64, 0);
    chk({tag, "_imm32"}, out_imm32, 0);
    chk({tag, "_tgt32"}, out_target32, 0);
    chk({tag, "_type"}, out_type32, 0);
    chk({tag, "_ill"}, out_illegal32, 0);
    chk({tag, "_mis"}, out_misalign32, 0);
    chk({tag, "_in_ready"}, in_ready32, 1);
    chk({tag, "_in_ready64"}, in_ready64, 1);
  endtask

  row_t rows[15];

  initial begin
    logic [6:0]  ops[12];
    logic [31:0] r32, lo, instr;
    logic [63:0] pc;
    logic        v, ordy, fl;

    rows[0]  = '{32'hFE000CE3, 64'h100, 64'hFFFF_FFFF_FFFF_FFF8, 64'hF8, 3'd3, 1'b0};
    rows[1]  = '{32'h001000EF, 64'h1000, 64'h800, 64'h1800, 3'd5, 1'b0};
    rows[2]  = '{32'h123452B7, 64'h200, 64'h1234_5000, 64'h204, 3'd4, 1'b0};
    rows[3]  = '{32'hFFF00093, 64'h204, 64'hFFFF_FFFF_FFFF_FFFF, 64'h208, 3'd1, 1'b0};
    rows[4]  = '{32'hFE21AE23, 64'h208, 64'hFFFF_FFFF_FFFF_FFFC, 64'h20C, 3'd2, 1'b0};
    rows[5]  = '{32'h800002B7, 64'h0, 64'hFFFF_FFFF_8000_0000, 64'h4, 3'd4, 1'b0};
    rows[6]  = '{32'h0000007F, 64'h300, 64'h0, 64'h304, 3'd0, 1'b1};
    rows[7]  = '{32'h00000033, 64'h400, 64'h0, 64'h404, 3'd0, 1'b0};
    rows[8]  = '{32'h00001297, 64'h10, 64'h1000, 64'h1010, 3'd4, 1'b0};
    rows[9]  = '{32'hFFFFF297, 64'h2000, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, 3'd4, 1'b0};
    rows[10] = '{32'h00008067, 64'h500, 64'h0, 64'h504, 3'd1, 1'b0};
    rows[11] = '{32'h0020006F, 64'h0, 64'h2, 64'h2, 3'd5, 1'b0};
    rows[12] = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 3'd1, 1'b0};
    rows[13] = '{32'h00000073, 64'h600, 64'h0, 64'h604, 3'd1, 1'b0};
    rows[14] = '{32'hFFC08067, 64'h700, 64'hFFFF_FFFF_FFFF_FFFC, 64'h704, 3'd1, 1'b0};

    ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc32 = '0; in_pc64 = '0;

    // Reset state
    step(0, 0, 0, 1, 0, 1, nul);
    step(0, 0, 0, 1, 0, 1, nul);
    chk("rst_in_ready", s_in_ready, 1);
    step(0, 0, 0, 1, 0, 0, nul);
    check_cleared("reset");

    // Table: back-to-back with out_ready high, exactly 2 cycles latency, one per cycle
    exact_lat = 1'b1;
    for (int i = 0; i < 15; i++) step(1, rows[i].instr, rows[i].pc, 1, 0, 0, from_row(rows[i]));
    drain();

    // Backpressure: lui/addi/sw with out_ready low for 3 cycles
    exact_lat = 1'b0;
    step(1, rows[2].instr, rows[2].pc, 1, 0, 0, from_row(rows[2]));
    step(1, rows[3].instr, rows[3].pc, 1, 0, 0, from_row(rows[3]));
    for (int k = 0; k < 3; k++) begin
      step(1, rows[4].instr, rows[4].pc, 0, 0, 0, from_row(rows[4]));
      chk("stall_in_ready", s_in_ready, 0);
      chk("stall_in_ready64", in_ready64, 0);
    end
    step(1, rows[4].instr, rows[4].pc, 1, 0, 0, from_row(rows[4]));
    chk("resume_in_ready", s_in_ready, 1);
    drain();

    // Flush with both stages full and a new input offered
    step(1, rows[2].instr, rows[2].pc, 0, 0, 0, from_row(rows[2]));
    step(1, rows[3].instr, rows[3].pc, 0, 0, 0, from_row(rows[3]));
    step(1, rows[4].instr, rows[4].pc, 1, 1, 0, from_row(rows[4]));
    chk("flush_in_ready", s_in_ready, 1);
    step(0, 0, 0, 1, 0, 0, nul);
    chk("flush_valid_a", out_valid32, 0);
    chk("flush_valid_a64", out_valid64, 0);
    step(0, 0, 0, 1, 0, 0, nul);
    chk("flush_valid_b", out_valid32, 0);
    chk("flush_valid_b64", out_valid64, 0);
    drain();

    // Reset mid-stream with both stages full
    step(1, rows[3].instr, rows[3].pc, 0, 0, 0, from_row(rows[3]));
    step(1, rows[4].instr, rows[4].pc, 0, 0, 0, from_row(rows[4]));
    step(1, rows[2].instr, rows[2].pc, 0, 0, 1, from_row(rows[2]));
    chk("midrst_in_ready", s_in_ready, 1);
    step(0, 0, 0, 1, 0, 0, nul);
    check_cleared("midrst");
    step(0, 0, 0, 1, 0, 0, nul);
    chk("midrst_valid_b", out_valid32, 0);
    drain();

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      r32 = $urandom();
      instr = {r32[31:7], ops[$urandom_range(0, 11)]};
      if ($urandom_range(0, 9) == 0) instr[6:0] = r32[6:0];
      lo = $urandom();
      if ($urandom_range(0, 3) != 0) lo[1:0] = 2'b00;
      pc = {$urandom(), lo};
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 49) == 0);
      step(v, instr, pc, ordy, fl, 0, ref_model(instr, pc));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
